// File: rtl/fetch_unit.sv
// ============================================================================
// Module      : fetch_unit
// Description : Instruction-fetch stage. Single-outstanding I-cache handshake,
//               redirect handling and IF/ID pipeline register.
//               Optional counters enabled by macro FETCH_PERF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        flush_d,
    input  logic [1:0]  pcsrc,
    input  logic [31:0] pc_target_e,
    input  logic [31:0] jalr_target,
    output logic        icache_req,
    output logic [31:0] icache_addr,
    input  logic        icache_rvalid,
    input  logic [31:0] icache_rdata,
    output logic [31:0] instr_d,
    output logic [31:0] pc_d,
    output logic [31:0] pcplus4_d,
    output logic        valid_d
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] miss_cycles,
    output logic [31:0] fetched_count
`endif
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_DROP  = 2'd2
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc_f;
    logic [31:0] r_pending_pc;
    logic [31:0] r_buf;
    logic        r_buf_valid;

    logic        w_req;
    logic        w_redirect;
    logic [31:0] w_target_raw;
    logic [31:0] w_target;
    logic        w_resp;
    logic        w_load;
    logic [31:0] w_load_data;
    logic [31:0] w_pc_plus4;

    assign w_req = ((r_state == S_FETCH) && !r_buf_valid && !stall)
                 || (r_state == S_WAIT) || (r_state == S_DROP);

    assign icache_req  = w_req;
    assign icache_addr = r_pc_f;

    assign w_redirect   = |pcsrc;
    assign w_target_raw = pcsrc[1] ? jalr_target : pc_target_e;
    assign w_target     = w_target_raw & ~32'h3;
    assign w_pc_plus4   = r_pc_f + 32'd4;

    // A response only counts for the live path; DROP responses are discarded.
    assign w_resp      = icache_rvalid && w_req && (r_state != S_DROP);
    assign w_load      = !w_redirect && !flush_d && !stall && (r_buf_valid || w_resp);
    assign w_load_data = r_buf_valid ? r_buf : icache_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_FETCH;
            r_pc_f       <= RESET_PC;
            r_pending_pc <= RESET_PC;
            r_buf        <= NOP_INSTR;
            r_buf_valid  <= 1'b0;
            instr_d      <= NOP_INSTR;
            pc_d         <= 32'd0;
            pcplus4_d    <= 32'd0;
            valid_d      <= 1'b0;
        end else if (w_redirect) begin
            instr_d     <= NOP_INSTR;
            valid_d     <= 1'b0;
            r_buf_valid <= 1'b0;
            // The cache still owes us a word for the old address: wait it out.
            if (w_req && !icache_rvalid) begin
                r_pending_pc <= w_target;
                r_state      <= S_DROP;
            end else begin
                r_pc_f  <= w_target;
                r_state <= S_FETCH;
            end
        end else if (r_state == S_DROP) begin
            if (icache_rvalid) begin
                r_pc_f  <= r_pending_pc;
                r_state <= S_FETCH;
            end
            if (flush_d || !stall) begin
                instr_d <= NOP_INSTR;
                valid_d <= 1'b0;
            end
        end else begin
            if (w_resp) begin
                r_state <= S_FETCH;
            end else if (w_req) begin
                r_state <= S_WAIT;
            end

            if (flush_d) begin
                // Word is lost and pc_f stays put, so the same address is refetched.
                instr_d <= NOP_INSTR;
                valid_d <= 1'b0;
                if (!stall) begin
                    r_buf_valid <= 1'b0;
                end
            end else if (stall) begin
                if (w_resp) begin
                    r_buf       <= icache_rdata;
                    r_buf_valid <= 1'b1;
                end
            end else if (w_load) begin
                instr_d     <= w_load_data;
                pc_d        <= r_pc_f;
                pcplus4_d   <= w_pc_plus4;
                valid_d     <= 1'b1;
                r_pc_f      <= w_pc_plus4;
                r_buf_valid <= 1'b0;
            end else begin
                instr_d <= NOP_INSTR;
                valid_d <= 1'b0;
            end
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            miss_cycles   <= 32'd0;
            fetched_count <= 32'd0;
        end else begin
            if (((r_state == S_WAIT) || (r_state == S_DROP)) && (miss_cycles != 32'hFFFF_FFFF)) begin
                miss_cycles <= miss_cycles + 32'd1;
            end
            if (w_load && (fetched_count != 32'hFFFF_FFFF)) begin
                fetched_count <= fetched_count + 32'd1;
            end
        end
    end
`endif

endmodule

`default_nettype wire
